// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory fabric: memory size, word-index
// slice of a byte address, and requester port IDs.
package dmem_pkg;

  localparam int MEM_BYTES_DEF = 16384;
  // A byte address selects a 32-bit word through bits [13:2].
  localparam int WORD_IDX_HI   = 13;
  localparam int WORD_IDX_LO   = 2;
  localparam int PORT_CORE     = 0;
  localparam int PORT_DMA      = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle between one requester and the data-memory arbiter.
//
// Handshake: a request transfers on a cycle where req_valid && req_ready.
// The master raises req_valid and holds req_we, req_addr and req_wdata
// stable until it sees req_ready; req_ready never depends on anything but
// the current request and arbitration state. Every transfer produces exactly
// one rsp_valid pulse on the following cycle; rsp_rdata and rsp_err keep
// their value until the next response on the same port.
interface dmem_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. Grant is combinational; last_gnt remembers
// the most recent winner so the other port wins the next contention.
// last_gnt resets to 1 so port 0 wins the first contention.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_gnt;

  // Pick the single requester, or the one that did not win last time.
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Record the winner of every grant.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_gnt <= 1'b1;
    else if (gnt[0]) last_gnt <= 1'b0;
    else if (gnt[1]) last_gnt <= 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one write port / async read port memory
// between the core LSU (port 0) and a DMA/debug master (port 1).
// Optional build macro DMEM_ARB_PRIO0_EN: fixed priority to port 0 with a
// 4-bit starvation counter that forces one port 1 grant after 15 losses.
// Without it, arbitration is plain round-robin via rr_arb2.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dmem_req_if.slave         port0,
  dmem_req_if.slave         port1,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_BYTES);

  logic [1:0] req;
  logic [1:0] gnt;
  logic       err0, err1;

  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              rsp0_err, rsp1_err;

  // No grants while reset is held, so every output reads zero.
  assign req = {port1.req_valid, port0.req_valid} & {2{~rst_i}};

  assign err0 = (port0.req_addr[1:0] != 2'b00) || (port0.req_addr >= MEM_LIMIT);
  assign err1 = (port1.req_addr[1:0] != 2'b00) || (port1.req_addr >= MEM_LIMIT);

`ifdef DMEM_ARB_PRIO0_EN
  localparam logic [3:0] STARVE_MAX = 4'd15;
  logic [3:0] starve_cnt;

  // Port 0 wins contention unless port 1 has starved for 15 cycles.
  always_comb begin
    gnt = 2'b00;
    if (req[PORT_DMA] && (starve_cnt == STARVE_MAX)) gnt[PORT_DMA]  = 1'b1;
    else if (req[PORT_CORE])                         gnt[PORT_CORE] = 1'b1;
    else if (req[PORT_DMA])                          gnt[PORT_DMA]  = 1'b1;
  end

  // Count cycles port 1 waits; any port 1 grant clears the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              starve_cnt <= 4'd0;
    else if (gnt[PORT_DMA]) starve_cnt <= 4'd0;
    else if (req[PORT_DMA]) starve_cnt <= starve_cnt + 4'd1;
  end
`else
  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   (req),
    .gnt   (gnt)
  );
`endif

  assign port0.req_ready = gnt[PORT_CORE];
  assign port1.req_ready = gnt[PORT_DMA];

  // Steer the granted port onto the memory; erroring writes never commit.
  always_comb begin
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (gnt[PORT_CORE]) begin
      mem_write_o = port0.req_we && !err0;
      mem_addr_o  = port0.req_addr;
      mem_wdata_o = port0.req_wdata;
    end else if (gnt[PORT_DMA]) begin
      mem_write_o = port1.req_we && !err1;
      mem_addr_o  = port1.req_addr;
      mem_wdata_o = port1.req_wdata;
    end
  end

  // Port 0 response: one-cycle pulse; data and error hold until the next one.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
    end else begin
      rsp0_valid <= gnt[PORT_CORE];
      if (gnt[PORT_CORE]) begin
        rsp0_err   <= err0;
        rsp0_rdata <= (port0.req_we || err0) ? '0 : mem_rdata_i;
      end
    end
  end

  // Port 1 response: same behaviour as port 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp1_valid <= gnt[PORT_DMA];
      if (gnt[PORT_DMA]) begin
        rsp1_err   <= err1;
        rsp1_rdata <= (port1.req_we || err1) ? '0 : mem_rdata_i;
      end
    end
  end

  assign port0.rsp_valid = rsp0_valid;
  assign port0.rsp_rdata = rsp0_rdata;
  assign port0.rsp_err   = rsp0_err;
  assign port1.rsp_valid = rsp1_valid;
  assign port1.rsp_rdata = rsp1_rdata;
  assign port1.rsp_err   = rsp1_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 4096 x 32 memory model.
// Build with DMEM_ARB_PRIO0_EN to exercise the fixed-priority variant.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;

  dmem_req_if p0_if ();
  dmem_req_if p1_if ();

  dmem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .port0       (p0_if),
    .port1       (p1_if),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[WORD_IDX_HI:WORD_IDX_LO]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[WORD_IDX_HI:WORD_IDX_LO]] <= mem_wdata;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    p0_if.req_valid = v; p0_if.req_we = we; p0_if.req_addr = a; p0_if.req_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    p1_if.req_valid = v; p1_if.req_we = we; p1_if.req_addr = a; p1_if.req_wdata = d;
  endtask

  task automatic idle_all();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [100:0] outs;
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    outs = {p0_if.req_ready, p1_if.req_ready, p0_if.rsp_valid, p1_if.rsp_valid,
            p0_if.rsp_rdata, p1_if.rsp_rdata, p0_if.rsp_err, p1_if.rsp_err,
            mem_write, mem_addr[31:0]};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h expected 0", outs); end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_write, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem_idle got %b/%h/%h expected 0/0/0", mem_write, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_write_read();
    drive0(1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    #1;
    checks++;
    if ({p0_if.req_ready, p1_if.req_ready, mem_write} !== 3'b101) begin
      errors++; $display("FAIL wr_grant got rdy0/rdy1/we %b expected 101", {p0_if.req_ready, p1_if.req_ready, mem_write});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== {32'h100, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_bus got %h/%h expected 100/deadbeef", mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata} !== {2'b10, 32'h0}) begin
      errors++; $display("FAIL wr_rsp got v/e/d %b/%b/%h expected 1/0/0", p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata);
    end
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    checks++;
    if ({p0_if.req_ready, mem_write} !== 2'b10) begin
      errors++; $display("FAIL rd_grant got rdy0/we %b expected 10", {p0_if.req_ready, mem_write});
    end
    tick();
    checks++;
    if ({p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_rsp got v/e/d %b/%b/%h expected 1/0/deadbeef", p0_if.rsp_valid, p0_if.rsp_err, p0_if.rsp_rdata);
    end
    idle_all();
    tick();
    checks++;
    if ({p0_if.rsp_valid, p0_if.rsp_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_hold got v/d %b/%h expected 0/deadbeef", p0_if.rsp_valid, p0_if.rsp_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    do_reset();
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    drive1(1'b1, 1'b0, 32'h100, 32'h0);
    for (int i = 0; i < 6; i++) begin
`ifdef DMEM_ARB_PRIO0_EN
      exp_g = 2'b01;
`else
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      #1;
      checks++;
      if ({p1_if.req_ready, p0_if.req_ready} !== exp_g) begin
        errors++; $display("FAIL rr_grant[%0d] got %b expected %b", i, {p1_if.req_ready, p0_if.req_ready}, exp_g);
      end
      tick();
      checks++;
      if ({p1_if.rsp_valid, p0_if.rsp_valid} !== exp_g) begin
        errors++; $display("FAIL rr_rsp[%0d] got %b expected %b", i, {p1_if.rsp_valid, p0_if.rsp_valid}, exp_g);
      end
    end
    idle_all();
    tick();
    checks++;
    if ({p1_if.rsp_valid, p0_if.rsp_valid, p0_if.rsp_rdata} !== {2'b00, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rr_tail got v1v0/d0 %b/%h expected 00/deadbeef", {p1_if.rsp_valid, p0_if.rsp_valid}, p0_if.rsp_rdata);
    end
  endtask

  task automatic test_err();
    logic [31:0] bad_addr [2];
    bad_addr[0] = 32'h102;
    bad_addr[1] = 32'h4000;
    for (int i = 0; i < 2; i++) begin
      drive1(1'b1, 1'b1, bad_addr[i], 32'h12345678);
      #1;
      checks++;
      if ({p1_if.req_ready, mem_write} !== 2'b10) begin
        errors++; $display("FAIL err_wr_grant[%0d] got rdy1/we %b expected 10", i, {p1_if.req_ready, mem_write});
      end
      tick();
      checks++;
      if ({p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata} !== {2'b11, 32'h0}) begin
        errors++; $display("FAIL err_wr_rsp[%0d] got v/e/d %b/%b/%h expected 1/1/0", i, p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata);
      end
    end
    drive1(1'b1, 1'b0, 32'h102, 32'h0);
    tick();
    checks++;
    if ({p1_if.rsp_err, p1_if.rsp_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL err_rd_rsp got e/d %b/%h expected 1/0", p1_if.rsp_err, p1_if.rsp_rdata);
    end
    drive1(1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    checks++;
    if ({p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL err_unchanged got v/e/d %b/%b/%h expected 1/0/deadbeef", p1_if.rsp_valid, p1_if.rsp_err, p1_if.rsp_rdata);
    end
    idle_all();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b1, 32'(i * 4), 32'(i + 1));
      tick();
    end
    idle_all();
    for (int i = 0; i < 4; i++) begin
      drive1(1'b1, 1'b0, 32'(i * 4), 32'h0);
      #1;
      checks++;
      if (p1_if.req_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b expected 1", i, p1_if.req_ready);
      end
      tick();
      checks++;
      if ({p1_if.rsp_valid, p1_if.rsp_rdata} !== {1'b1, 32'(i + 1)}) begin
        errors++; $display("FAIL b2b_rsp[%0d] got v/d %b/%h expected 1/%h", i, p1_if.rsp_valid, p1_if.rsp_rdata, i + 1);
      end
    end
    idle_all();
    tick();
    checks++;
    if (p1_if.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_tail got %b expected 0", p1_if.rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [100:0] outs;
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    checks++;
    if (p0_if.req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_accept got %b expected 1", p0_if.req_ready);
    end
    tick();
    idle_all();
    rst = 1'b1;
    #1;
    outs = {p0_if.req_ready, p1_if.req_ready, p0_if.rsp_valid, p1_if.rsp_valid,
            p0_if.rsp_rdata, p1_if.rsp_rdata, p0_if.rsp_err, p1_if.rsp_err,
            mem_write, mem_addr[31:0]};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL mid_rst_outputs got %h expected 0", outs); end
    tick();
    checks++;
    if (p0_if.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_no_rsp got %b expected 0", p0_if.rsp_valid);
    end
    rst = 1'b0;
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    drive1(1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    checks++;
    if ({p1_if.req_ready, p0_if.req_ready} !== 2'b01) begin
      errors++; $display("FAIL mid_first_contention got %b expected 01", {p1_if.req_ready, p0_if.req_ready});
    end
    tick();
    idle_all();
    tick();
  endtask

`ifdef DMEM_ARB_PRIO0_EN
  task automatic test_prio();
    logic [1:0] exp_g;
    do_reset();
    drive0(1'b1, 1'b0, 32'h100, 32'h0);
    drive1(1'b1, 1'b0, 32'h100, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      exp_g = (c == 16) ? 2'b10 : 2'b01;
      #1;
      checks++;
      if ({p1_if.req_ready, p0_if.req_ready} !== exp_g) begin
        errors++; $display("FAIL prio_grant[%0d] got %b expected %b", c, {p1_if.req_ready, p0_if.req_ready}, exp_g);
      end
      tick();
    end
    idle_all();
    tick();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_round_robin();
    test_err();
    test_back_to_back();
    test_reset_mid();
`ifdef DMEM_ARB_PRIO0_EN
    test_prio();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
